// File: rtl/sdrc_rfsh_pkg.sv
// Shared types and constants for the SDRAM refresh scheduler.
package sdrc_rfsh_pkg;

  localparam int TMR_W_DEF  = 12;
  localparam int ROW_W_DEF  = 3;
  localparam int PEND_W_DEF = 4;
  localparam int PEND_MAX   = (1 << PEND_W_DEF) - 1;

  localparam int ERR_OVF  = 0;
  localparam int ERR_SPUR = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_REQ
  } state_t;

endpackage

// File: rtl/sdrc_rfsh_tmr.sv
// Reloadable refresh interval down-counter; tick marks the last cycle of each interval.
module sdrc_rfsh_tmr
  import sdrc_rfsh_pkg::*;
#(
  parameter int TMR_W = TMR_W_DEF
) (
  input  logic             sdram_clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [TMR_W-1:0] cfg_sdr_rfsh,
  output logic             tick,
  output logic [TMR_W-1:0] timer
);

  logic [TMR_W-1:0] timer_reg;

  assign tick  = !clr && !load && (timer_reg == TMR_W'(1));
  assign timer = timer_reg;

  // A value of 0 or 1 reloads, so a disabled timer restarts once cfg becomes non-zero.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_reg <= '0;
    end else if (clr) begin
      timer_reg <= '0;
    end else if (load || timer_reg <= TMR_W'(1)) begin
      timer_reg <= cfg_sdr_rfsh;
    end else begin
      timer_reg <= timer_reg - TMR_W'(1);
    end
  end

endmodule

// File: rtl/sdrc_rfsh_sched.sv
// Refresh scheduler: accumulates refresh obligations per interval and requests slots to retire them.
module sdrc_rfsh_sched
  import sdrc_rfsh_pkg::*;
#(
  parameter int TMR_W  = TMR_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              sdram_clk,
  input  logic              reset_n,
  input  logic              sdr_init_done,
  input  logic [TMR_W-1:0]  cfg_sdr_rfsh,
  input  logic [ROW_W-1:0]  cfg_rfsh_rows,
  input  logic [PEND_W-1:0] cfg_rfsh_urg,
  input  logic              x2b_refresh,
  output logic              rfsh_req,
  output logic              rfsh_urgent,
  output logic [PEND_W-1:0] rfsh_pend_cnt,
  output logic [TMR_W-1:0]  rfsh_timer,
  output logic [1:0]        rfsh_err
);

  localparam int SUM_W    = ((PEND_W > ROW_W) ? PEND_W : ROW_W) + 1;
  localparam int PEND_TOP = (1 << PEND_W) - 1;

  state_t            state_reg;
  logic [PEND_W-1:0] pend_reg;
  logic              req_reg;
  logic              urg_reg;
  logic [1:0]        err_reg;

  logic              tick;
  logic [ROW_W-1:0]  rows_eff;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  raw;
  logic              ack;
  logic              spur;
  logic              ovf;
  logic [PEND_W-1:0] pend_next;
  logic              urg_next;
  logic              req_set;

  sdrc_rfsh_tmr #(.TMR_W(TMR_W)) u_tmr (
    .sdram_clk    (sdram_clk),
    .reset_n      (reset_n),
    .clr          (!sdr_init_done),
    .load         (state_reg == S_IDLE),
    .cfg_sdr_rfsh (cfg_sdr_rfsh),
    .tick         (tick),
    .timer        (rfsh_timer)
  );

  // The tick is added before the ack is qualified, so an ack coinciding with a tick is never spurious.
  always_comb begin
    rows_eff  = (cfg_rfsh_rows == '0) ? ROW_W'(1) : cfg_rfsh_rows;
    sum       = SUM_W'(pend_reg) + (tick ? SUM_W'(rows_eff) : SUM_W'(0));
    ack       = x2b_refresh && (sum != '0);
    spur      = x2b_refresh && (sum == '0);
    raw       = sum - SUM_W'(ack);
    ovf       = raw > SUM_W'(PEND_TOP);
    pend_next = ovf ? PEND_W'(PEND_TOP) : raw[PEND_W-1:0];
    urg_next  = (pend_next != '0) && (pend_next >= cfg_rfsh_urg);
    req_set   = SUM_W'(pend_next) >= SUM_W'(rows_eff);
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      pend_reg  <= '0;
      req_reg   <= 1'b0;
      urg_reg   <= 1'b0;
      err_reg   <= '0;
    end else if (!sdr_init_done) begin
      state_reg <= S_IDLE;
      pend_reg  <= '0;
      req_reg   <= 1'b0;
      urg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_COUNT;
          pend_reg  <= '0;
          req_reg   <= 1'b0;
          urg_reg   <= 1'b0;
        end
        S_COUNT, S_REQ: begin
          pend_reg          <= pend_next;
          urg_reg           <= urg_next;
          err_reg[ERR_OVF]  <= err_reg[ERR_OVF] | ovf;
          err_reg[ERR_SPUR] <= err_reg[ERR_SPUR] | spur;
          if (state_reg == S_COUNT && req_set) begin
            state_reg <= S_REQ;
            req_reg   <= 1'b1;
          end else if (state_reg == S_REQ && pend_next == '0) begin
            state_reg <= S_COUNT;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign rfsh_req      = req_reg;
  assign rfsh_urgent   = urg_reg;
  assign rfsh_pend_cnt = pend_reg;
  assign rfsh_err      = err_reg;

endmodule

// File: tb/tb_sdrc_rfsh_sched.sv
// Self-checking bench for sdrc_rfsh_sched: directed scenarios plus random traffic against a cycle model.
module tb_sdrc_rfsh_sched;

  logic        sdram_clk = 1'b0;
  logic        reset_n;
  logic        sdr_init_done;
  logic [11:0] cfg_sdr_rfsh;
  logic [2:0]  cfg_rfsh_rows;
  logic [3:0]  cfg_rfsh_urg;
  logic        x2b_refresh;
  logic        rfsh_req;
  logic        rfsh_urgent;
  logic [3:0]  rfsh_pend_cnt;
  logic [11:0] rfsh_timer;
  logic [1:0]  rfsh_err;

  sdrc_rfsh_sched dut (
    .sdram_clk     (sdram_clk),
    .reset_n       (reset_n),
    .sdr_init_done (sdr_init_done),
    .cfg_sdr_rfsh  (cfg_sdr_rfsh),
    .cfg_rfsh_rows (cfg_rfsh_rows),
    .cfg_rfsh_urg  (cfg_rfsh_urg),
    .x2b_refresh   (x2b_refresh),
    .rfsh_req      (rfsh_req),
    .rfsh_urgent   (rfsh_urgent),
    .rfsh_pend_cnt (rfsh_pend_cnt),
    .rfsh_timer    (rfsh_timer),
    .rfsh_err      (rfsh_err)
  );

  always #5 sdram_clk = ~sdram_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, plain integers.
  int m_active, m_timer, m_pend, m_err, m_req, m_urg;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_timer = 0; m_pend = 0; m_err = 0; m_req = 0; m_urg = 0;
  endfunction

  // One clock edge of the scheduler, evaluated from the current inputs.
  function automatic void model_step();
    int rows, add, s, n;
    bit tick;
    if (!sdr_init_done) begin
      m_active = 0; m_timer = 0; m_pend = 0; m_req = 0; m_urg = 0;
      return;
    end
    if (!m_active) begin
      m_active = 1; m_timer = int'(cfg_sdr_rfsh); m_pend = 0; m_req = 0; m_urg = 0;
      return;
    end
    tick = (m_timer == 1);
    m_timer = (m_timer <= 1) ? int'(cfg_sdr_rfsh) : m_timer - 1;
    rows = (cfg_rfsh_rows == 0) ? 1 : int'(cfg_rfsh_rows);
    add  = tick ? rows : 0;
    s    = m_pend + add;
    n    = s;
    if (x2b_refresh) begin
      if (s == 0) m_err = m_err | 2;
      else n = s - 1;
    end
    if (n > 15) begin
      n = 15;
      m_err = m_err | 1;
    end
    m_req  = m_req ? (n != 0) : (n >= rows);
    m_urg  = (n != 0 && n >= int'(cfg_rfsh_urg)) ? 1 : 0;
    m_pend = n;
  endfunction

  task automatic compare_all();
    chk("req", rfsh_req, m_req);
    chk("urgent", rfsh_urgent, m_urg);
    chk("pend", rfsh_pend_cnt, m_pend);
    chk("timer", rfsh_timer, m_timer);
    chk("err", rfsh_err, m_err);
  endtask

  task automatic cycle();
    model_step();
    @(posedge sdram_clk);
    @(negedge sdram_clk);
    cyc++;
    compare_all();
  endtask

  int e0;
  int ack_cd;
  int rises[$];
  bit prev;
  bit done;
  int req_cnt;

  initial begin
    reset_n = 1'b0; sdr_init_done = 1'b0; cfg_sdr_rfsh = 12'd100;
    cfg_rfsh_rows = 3'd1; cfg_rfsh_urg = 4'd4; x2b_refresh = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    reset_n = 1'b1;

    // Basic period with acks three cycles after each request.
    sdr_init_done = 1'b1;
    e0 = cyc + 1;
    ack_cd = 0;
    for (int i = 0; i < 230; i++) begin
      x2b_refresh = (ack_cd == 1);
      if (ack_cd > 0) ack_cd--;
      prev = rfsh_req;
      cycle();
      if (!prev && rfsh_req) begin
        rises.push_back(cyc - e0);
        ack_cd = 3;
      end
    end
    x2b_refresh = 1'b0;
    chk("basic_rise_count", rises.size(), 2);
    if (rises.size() >= 2) begin
      chk("basic_rise1", rises[0], 100);
      chk("basic_rise2", rises[1], 200);
    end
    $display("basic period: %0d request rises seen", rises.size());

    // Batch of 4 per interval, no acks, overflow on the 4th tick.
    sdr_init_done = 1'b0;
    cycle();
    cfg_rfsh_rows = 3'd4; cfg_sdr_rfsh = 12'd50; sdr_init_done = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 205; i++) begin
      cycle();
      if (cyc - e0 == 50) begin
        chk("batch_pend1", rfsh_pend_cnt, 4);
        chk("batch_req1", rfsh_req, 1);
        chk("batch_urg1", rfsh_urgent, 1);
      end
      if (cyc - e0 == 150) chk("batch_pend3", rfsh_pend_cnt, 12);
      if (cyc - e0 == 200) begin
        chk("batch_pend_sat", rfsh_pend_cnt, 15);
        chk("batch_err_ovf", rfsh_err, 1);
      end
    end
    $display("batch: pend=%0d err=%0d", rfsh_pend_cnt, rfsh_err);

    // Asynchronous reset in the middle of a count.
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req", rfsh_req, 0);
    chk("arst_pend", rfsh_pend_cnt, 0);
    chk("arst_timer", rfsh_timer, 0);
    chk("arst_err", rfsh_err, 0);
    chk("arst_urg", rfsh_urgent, 0);
    cfg_sdr_rfsh = 12'd20; cfg_rfsh_rows = 3'd1; cfg_rfsh_urg = 4'd2;
    @(posedge sdram_clk);
    @(negedge sdram_clk);
    reset_n = 1'b1;
    compare_all();
    $display("async reset: outputs cleared without an edge");

    // Spurious ack with nothing pending.
    for (int i = 0; i < 5; i++) cycle();
    x2b_refresh = 1'b1;
    cycle();
    x2b_refresh = 1'b0;
    chk("spur_err", rfsh_err, 2);
    chk("spur_pend", rfsh_pend_cnt, 0);
    $display("spurious ack: err=%0d", rfsh_err);

    // Tick and ack on the same edge with two pending.
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      x2b_refresh = (m_timer == 1 && m_pend == 2);
      cycle();
      if (x2b_refresh) begin
        chk("simul_pend", rfsh_pend_cnt, 2);
        chk("simul_req", rfsh_req, 1);
        done = 1'b1;
      end
    end
    x2b_refresh = 1'b0;
    if (!done) chk("simul_timeout", 0, 1);
    $display("simultaneous tick/ack: pend=%0d", rfsh_pend_cnt);

    // Re-init while requesting with three pending.
    for (int i = 0; i < 100 && m_pend != 3; i++) cycle();
    chk("reinit_pend3", rfsh_pend_cnt, 3);
    chk("reinit_req_hi", rfsh_req, 1);
    sdr_init_done = 1'b0;
    cycle();
    chk("reinit_req", rfsh_req, 0);
    chk("reinit_pend", rfsh_pend_cnt, 0);
    chk("reinit_timer", rfsh_timer, 0);
    chk("reinit_err", rfsh_err, 2);
    sdr_init_done = 1'b1;
    e0 = cyc + 1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      prev = rfsh_req;
      cycle();
      if (!prev && rfsh_req) begin
        chk("reinit_rise", cyc - e0, 20);
        done = 1'b1;
      end
    end
    if (!done) chk("reinit_timeout", 0, 1);
    $display("re-init: first request after %0d cycles", cyc - e0);

    // Disabled timer, then enable to confirm reload.
    sdr_init_done = 1'b0;
    cycle();
    cfg_sdr_rfsh = 12'd0; sdr_init_done = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      cycle();
      req_cnt += int'(rfsh_req);
    end
    chk("disabled_req_cnt", req_cnt, 0);
    chk("disabled_timer", rfsh_timer, 0);
    cfg_sdr_rfsh = 12'd7;
    req_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      req_cnt += int'(rfsh_req);
    end
    chk("enabled_req_seen", int'(req_cnt > 0), 1);
    $display("disabled timer: no requests over 5000 cycles");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sdr_init_done = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 63) == 0) cfg_sdr_rfsh = 12'($urandom_range(0, 30));
      if ($urandom_range(0, 127) == 0) cfg_rfsh_rows = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 127) == 0) cfg_rfsh_urg = 4'($urandom_range(0, 15));
      x2b_refresh = ($urandom_range(0, 3) == 0);
      cycle();
    end
    x2b_refresh = 1'b0;
    $display("random traffic: %0d cycles total", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
